// File: rtl/datapath_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the phase-1 CPU datapath.
// Drives all datapath strobes, one-hot register selects and ALUselect.
module datapath_control_unit #(
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              IR,
    input  logic                     stop,
    output logic                     PCout,
    output logic                     MARin,
    output logic                     IncPC,
    output logic                     ZIn,
    output logic                     ZLowout,
    output logic                     ZHighout,
    output logic                     PCin,
    output logic                     Read,
    output logic                     MDRin,
    output logic                     MDRout,
    output logic                     IRin,
    output logic                     Yin,
    output logic                     HIin,
    output logic                     LOin,
    output logic [(1<<ADDR_W)-1:0]   Rin,
    output logic [(1<<ADDR_W)-1:0]   Rout,
    output logic [3:0]               ALUselect,
    output logic                     run
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state;

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] ra, rb, rc;
    logic              is_exec;
    logic              is_muldiv;
    logic [3:0]        alu_code;
    logic              unused_bits;

    assign opcode      = IR[31:27];
    assign ra          = IR[26 -: ADDR_W];
    assign rb          = IR[22 -: ADDR_W];
    assign rc          = IR[18 -: ADDR_W];
    assign unused_bits = ^IR[14:0];
    assign is_muldiv   = (opcode == OP_MUL) || (opcode == OP_DIV);

    always_comb begin
        is_exec  = 1'b1;
        alu_code = '0;
        case (opcode)
            OP_ADD:  alu_code = 4'b0001;
            OP_SUB:  alu_code = 4'b0010;
            OP_SHR:  alu_code = 4'b0111;
            OP_SHL:  alu_code = 4'b1000;
            OP_ROR:  alu_code = 4'b1001;
            OP_ROL:  alu_code = 4'b1010;
            OP_AND:  alu_code = 4'b0011;
            OP_OR:   alu_code = 4'b0100;
            OP_MUL:  alu_code = 4'b0101;
            OP_DIV:  alu_code = 4'b0110;
            default: is_exec  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
        end else begin
            case (state)
                RST:  state <= T0;
                T0:   state <= stop ? HALT : T1;
                T1:   state <= T2;
                T2:   state <= T3;
                // Unknown opcodes behave as nop and go straight back to fetch.
                T3: begin
                    if (is_exec)                  state <= T4;
                    else if (opcode == OP_HALT)   state <= HALT;
                    else                          state <= T0;
                end
                T4:   state <= T5;
                T5:   state <= is_muldiv ? T6 : T0;
                T6:   state <= T0;
                HALT: state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    // IR is decoded combinationally so T3 sees the instruction loaded at the end of T2.
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        ZIn       = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        ALUselect = '0;
        run       = (state != RST) && (state != HALT);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                ZIn   = 1'b1;
            end
            T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_exec) begin
                    Rout[rb] = 1'b1;
                    Yin      = 1'b1;
                end
            end
            T4: begin
                Rout[rc]  = 1'b1;
                ALUselect = alu_code;
                ZIn       = 1'b1;
            end
            T5: begin
                ZLowout = 1'b1;
                if (is_muldiv) LOin    = 1'b1;
                else           Rin[ra] = 1'b1;
            end
            T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Self-checking bench for datapath_control_unit: directed test-plan cases,
// then randomized instruction streams against a cycle-count reference model.
module tb_datapath_control_unit;

    logic        clk = 1'b0;
    logic        reset, stop;
    logic [31:0] IR;
    logic PCout, MARin, IncPC, ZIn, ZLowout, ZHighout, PCin, Read;
    logic MDRin, MDRout, IRin, Yin, HIin, LOin, run;
    logic [15:0] Rin, Rout;
    logic [3:0]  ALUselect;

    datapath_control_unit #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .IR(IR), .stop(stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .ZIn(ZIn),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .ALUselect(ALUselect), .run(run)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Strobe vector bit positions (MSB first).
    localparam int B_PCOUT = 13, B_MARIN = 12, B_INCPC = 11, B_ZIN = 10;
    localparam int B_ZLOW = 9, B_ZHIGH = 8, B_PCIN = 7, B_READ = 6;
    localparam int B_MDRIN = 5, B_MDROUT = 4, B_IRIN = 3, B_YIN = 2;
    localparam int B_HIIN = 1, B_LOIN = 0;

    // Reference model: position k (cycles since fetch began) inside the instruction.
    logic m_rst = 1'b1;
    logic m_halt = 1'b0;
    int   m_k = 0;
    logic load_pending = 1'b0;
    logic [31:0] next_ir;

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3:  return 4'd1;
            5'd4:  return 4'd2;
            5'd5:  return 4'd7;
            5'd6:  return 4'd8;
            5'd7:  return 4'd9;
            5'd8:  return 4'd10;
            5'd9:  return 4'd3;
            5'd10: return 4'd4;
            5'd15: return 4'd5;
            5'd16: return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit is_md(input logic [4:0] op);
        return op == 5'd15 || op == 5'd16;
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        if (is_md(op)) return 7;
        if (alu_of(op) != 4'd0) return 6;
        return 4;
    endfunction

    // {run, strobes[13:0], Rin, Rout, ALUselect}
    function automatic logic [50:0] expect_out(input logic rst, input logic halt,
                                               input int k, input logic [31:0] ir);
        logic [13:0] s;
        logic [15:0] ri, ro;
        logic [3:0]  al;
        logic [4:0]  op;
        s = '0; ri = '0; ro = '0; al = '0;
        op = ir[31:27];
        if (rst || halt) return '0;
        case (k)
            0: begin s[B_PCOUT] = 1; s[B_MARIN] = 1; s[B_INCPC] = 1; s[B_ZIN] = 1; end
            1: begin s[B_ZLOW] = 1; s[B_PCIN] = 1; s[B_READ] = 1; s[B_MDRIN] = 1; end
            2: begin s[B_MDROUT] = 1; s[B_IRIN] = 1; end
            3: if (alu_of(op) != 4'd0) begin ro = 16'd1 << ir[22:19]; s[B_YIN] = 1; end
            4: begin ro = 16'd1 << ir[18:15]; al = alu_of(op); s[B_ZIN] = 1; end
            5: begin
                s[B_ZLOW] = 1;
                if (is_md(op)) s[B_LOIN] = 1; else ri = 16'd1 << ir[26:23];
            end
            6: begin s[B_ZHIGH] = 1; s[B_HIIN] = 1; end
            default: ;
        endcase
        return {1'b1, s, ri, ro, al};
    endfunction

    always @(posedge clk) begin
        load_pending <= !reset && !m_rst && !m_halt && m_k == 2;
        if (reset) begin
            m_rst <= 1'b1; m_halt <= 1'b0; m_k <= 0;
        end else if (m_rst) begin
            m_rst <= 1'b0; m_k <= 0;
        end else if (!m_halt) begin
            if (m_k == 0 && stop)                        m_halt <= 1'b1;
            else if (m_k == 3 && IR[31:27] == 5'b11011)  m_halt <= 1'b1;
            else if (m_k + 1 == instr_len(IR[31:27]))    m_k <= 0;
            else                                         m_k <= m_k + 1;
        end
    end

    function automatic logic [50:0] dut_out();
        return {run, PCout, MARin, IncPC, ZIn, ZLowout, ZHighout, PCin, Read,
                MDRin, MDRout, IRin, Yin, HIin, LOin, Rin, Rout, ALUselect};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: the datapath loads IR after a T2 cycle, then compare at the falling edge.
    task automatic tick();
        logic [50:0] e;
        @(posedge clk);
        #1;
        if (load_pending) IR = next_ir;
        @(negedge clk);
        e = expect_out(m_rst, m_halt, m_k, IR);
        check("model", {13'd0, dut_out()}, {13'd0, e});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [4:0] ops [11] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16, 5'd26};

    initial begin
        reset = 1'b1; stop = 1'b0; IR = '0; next_ir = '0;
        ticks(2);
        check("rst_all_zero", {13'd0, dut_out()}, 64'd0);
        reset = 1'b0;
        next_ir = 32'h4A920000;
        tick();
        check("t0_strobes", {60'd0, PCout, MARin, IncPC, ZIn}, 64'hF);
        check("t0_run", {63'd0, run}, 64'd1);
        ticks(3);
        check("and_t3_rout", {48'd0, Rout}, 64'h0004);
        check("and_t3_yin", {63'd0, Yin}, 64'd1);
        tick();
        check("and_t4_rout", {48'd0, Rout}, 64'h0010);
        check("and_t4_alu", {60'd0, ALUselect}, 64'h3);
        check("and_t4_zin", {63'd0, ZIn}, 64'd1);
        tick();
        check("and_t5_rin", {48'd0, Rin}, 64'h0020);
        check("and_t5_zlow", {63'd0, ZLowout}, 64'd1);
        next_ir = 32'h79180000;
        tick();
        check("and_back_t0", {63'd0, PCout}, 64'd1);
        ticks(3);
        check("mul_t3_rout", {48'd0, Rout}, 64'h0008);
        stop = 1'b1;
        tick();
        check("mul_t4_rout", {48'd0, Rout}, 64'h0001);
        check("mul_t4_alu", {60'd0, ALUselect}, 64'h5);
        stop = 1'b0;
        tick();
        check("mul_t5", {61'd0, ZLowout, LOin, |Rin}, 64'h6);
        tick();
        check("mul_t6", {61'd0, ZHighout, HIin, |Rin}, 64'h6);
        tick();
        check("mul_back_t0", {63'd0, PCout}, 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_halt", {13'd0, dut_out()}, 64'd0);
        ticks(3);
        check("stop_no_t1", {13'd0, dut_out()}, 64'd0);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        check("after_reset_t0", {63'd0, PCout}, 64'd1);
        next_ir = 32'hD8000000;
        ticks(4);
        for (int i = 0; i < 20; i++) tick();
        check("halt_idle", {13'd0, dut_out()}, 64'd0);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        check("halt_exit_t0", {63'd0, PCout}, 64'd1);
        next_ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        ticks(4);
        check("add_t4_alu", {60'd0, ALUselect}, 64'h1);
        reset = 1'b1;
        tick();
        check("mid_reset_zero", {13'd0, dut_out()}, 64'd0);
        reset = 1'b0;
        tick();
        check("mid_reset_t0", {63'd0, PCout}, 64'd1);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            if ($urandom_range(15) == 0)      op = 5'b11011;
            else if ($urandom_range(9) == 0)  op = 5'($urandom);
            else                              op = ops[$urandom_range(10)];
            next_ir = {op, 27'($urandom)};
            stop  = ($urandom_range(7) == 0);
            reset = m_halt ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0);
            if ($urandom_range(19) == 0) begin
                stop = 1'b1; reset = 1'b1;
            end
            tick();
        end
        reset = 1'b0; stop = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
